uart_tx_7n: RTL and testbench
=============================

Name: uart_tx_7n

Overview:
- UART transmitter; consumes words from the TX-side depth_fifo and serialises them onto the line.
- Frames: 1 start bit (0), p_data_bits data bits LSB-first, p_stop_bits stop bits (1); no parity unless the optional feature is compiled in.
- Pops the FIFO through its valid / read-enable handshake; bit timing comes from an internal clock-divider counter.

Parameters:
- p_clks_per_bit, 16, clock cycles per line bit; must be >= 2.
- p_data_bits, 7, data bits per frame; legal range 5..8.
- p_stop_bits, 1, stop bits per frame; legal values 1 or 2.
- p_word_size, 8, width of data_i; matches the FIFO word size; must be >= p_data_bits.

Ports:
- clk_i  in  1  system clock, all logic on rising edge.
- rst_i  in  1  synchronous reset, active-high.
- data_i  in  p_word_size  FIFO head word (FIFO data_o); only bits [p_data_bits-1:0] are sent.
- valid_i  in  1  FIFO not empty (FIFO read_valid_o).
- rd_en_o  out  1  FIFO pop strobe (to FIFO read_enable_i); combinational.
- tx_o  out  1  serial line, idles high; registered.
- busy_o  out  1  high while a frame is in progress; registered.

Behaviour:
- Reset values:
  - tx_o=1, busy_o=0, state=IDLE, baud counter=0, bit counter=0, shift register=0.
  - rd_en_o=0 whenever rst_i=1.
- States: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- rd_en_o = (state==IDLE) & valid_i & ~rst_i.
  - Exactly one pop per frame; never asserted outside IDLE.
  - data_i is latched into the shift register on the same edge as the pop.
- Bit timing:
  - Baud counter loads p_clks_per_bit-1 on each state or bit entry and decrements to 0.
  - A bit ends on the cycle the counter is 0.
  - Counter width is $clog2(p_clks_per_bit).
- Latency: pop at edge N; tx_o=0 (start bit) from cycle N+1 for p_clks_per_bit cycles.
- IDLE: tx_o=1, busy_o=0. valid_i=1 -> START, busy_o=1.
- START: tx_o=0 for one bit time, then DATA with bit counter=0.
- DATA:
  - tx_o = shift[0]; shift right at each bit end.
  - After p_data_bits bits -> PARITY if compiled in, else STOP.
- STOP:
  - tx_o=1 for p_stop_bits bit times.
  - Then IDLE; busy_o drops on the same edge.
- Frame length: (1 + p_data_bits + p_stop_bits) * p_clks_per_bit cycles.
  - Back-to-back frames have exactly 1 extra idle clock (the IDLE pop cycle) between them.
- valid_i changes mid-frame are ignored; data_i is only sampled at the pop.
- Empty FIFO (valid_i=0): remain in IDLE, line high, no pop.
- Reset mid-frame:
  - Next cycle tx_o=1, busy_o=0, state=IDLE.
  - Frame aborted; the word is lost and not re-popped.
  - No pop during any cycle with rst_i=1.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state between DATA and STOP, one bit time.
  - tx_o = even parity, i.e. the XOR of the p_data_bits sent.
  - Parity is computed at the pop from data_i and held in a register.
  - Frame grows by one bit time.
- Undefined: no PARITY state, no parity register; the frame is exactly as above.

Decomposition:
- Shared package uart_pkg:
  - State enum typedef tx_state_t (IDLE, START, DATA, PARITY, STOP).
  - Constants UART_START_BIT=1'b0, UART_STOP_BIT=1'b1.
- One natural sub-module: uart_baud_tick.
  - Loadable down-counter producing a bit-end pulse.
  - Reused later by the receiver.

Test Plan:
- Reset then idle: rst_i=1 for 3 cycles, valid_i=0 -> tx_o=1, busy_o=0, rd_en_o=0 throughout, including 100 cycles after release.
- Single frame (p_clks_per_bit=4): FIFO holds 7'h55.
  - rd_en_o pulses once.
  - tx_o = 0,1,0,1,0,1,0,1,1, each held 4 cycles (36 cycles total).
  - busy_o high for exactly 36 cycles.
- Back-to-back: FIFO holds 7'h00, 7'h7F.
  - Two pops, 37 cycles apart.
  - Second frame's start bit begins 1 cycle after the first frame's stop bit ends.
  - Data bits are 0000000 then 1111111.
- Empty FIFO mid-stream: one word 7'h2A, then valid_i=0 -> exactly one pop, one frame, then tx_o stays 1.
- Reset mid-frame: assert rst_i during data bit 3 of 7'h55 -> tx_o=1 and busy_o=0 next cycle; the next frame starts only after rst_i releases with a fresh pop.
- UART_TX_PARITY_EN defined, 7'h07 -> parity bit = 1 inserted after bit 6; frame is 40 cycles at p_clks_per_bit=4.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding and line-level constants
package uart_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
    localparam logic UART_START_BIT = 1'b0;
    localparam logic UART_STOP_BIT  = 1'b1;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: loadable down-counter, tick high while the count sits at zero
module uart_baud_tick #(
    parameter int p_clks_per_bit = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic tick
);
    localparam int CW = (p_clks_per_bit > 1) ? $clog2(p_clks_per_bit) : 1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst) cnt <= '0;
        else if (load) cnt <= CW'(p_clks_per_bit - 1);
        else if (cnt != '0) cnt <= cnt - CW'(1);
    end
    assign tick = (cnt == '0);
endmodule

// File: rtl/uart_tx_7n.sv
// uart_tx_7n: UART transmitter popping words from a FIFO and serialising them LSB-first.
// Optional even parity bit after the data bits when UART_TX_PARITY_EN is defined.
module uart_tx_7n
    import uart_pkg::*;
#(
    parameter int p_clks_per_bit = 16,
    parameter int p_data_bits    = 7,
    parameter int p_stop_bits    = 1,
    parameter int p_word_size    = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [p_word_size-1:0] data_i,
    input  logic                   valid_i,
    output logic                   rd_en_o,
    output logic                   tx_o,
    output logic                   busy_o
);
    localparam int BW = $clog2(p_data_bits);
    tx_state_t state, state_d;
    logic [p_data_bits-1:0] shift, shift_d;
    logic [BW-1:0] bit_cnt, bit_d;
    logic tx_d, pop, tick, load, par_tx, unused_hi;
    assign unused_hi = ^data_i;
    assign pop = (state == IDLE) && valid_i && !rst_i;
    assign rd_en_o = pop;
    // every bit end in a frame restarts the bit timer, as does the pop itself
    assign load = pop || (state != IDLE && tick);
    uart_baud_tick #(.p_clks_per_bit(p_clks_per_bit)) u_baud (
        .clk  (clk_i),
        .rst  (rst_i),
        .load (load),
        .tick (tick)
    );
`ifdef UART_TX_PARITY_EN
    logic par;
    always_ff @(posedge clk_i) begin
        if (rst_i) par <= 1'b0;
        else if (pop) par <= ^data_i[p_data_bits-1:0];
    end
    assign par_tx = par;
`else
    assign par_tx = UART_STOP_BIT;
`endif
    always_comb begin
        state_d = state;
        shift_d = shift;
        bit_d   = bit_cnt;
        case (state)
            IDLE: if (pop) begin
                state_d = START;
                shift_d = data_i[p_data_bits-1:0];
            end
            START: if (tick) begin
                state_d = DATA;
                bit_d   = '0;
            end
            DATA: if (tick) begin
                if (bit_cnt == BW'(p_data_bits - 1)) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                    bit_d = '0;
                end else begin
                    shift_d = shift >> 1;
                    bit_d   = bit_cnt + BW'(1);
                end
            end
            PARITY: if (tick) state_d = STOP;
            STOP: if (tick) begin
                if (bit_cnt == BW'(p_stop_bits - 1)) state_d = IDLE;
                else bit_d = bit_cnt + BW'(1);
            end
            default: state_d = IDLE;
        endcase
        tx_d = (state_d == START)  ? UART_START_BIT :
               (state_d == DATA)   ? shift_d[0] :
               (state_d == PARITY) ? par_tx : UART_STOP_BIT;
    end
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            shift   <= '0;
            bit_cnt <= '0;
            tx_o    <= UART_STOP_BIT;
            busy_o  <= 1'b0;
        end else begin
            state   <= state_d;
            shift   <= shift_d;
            bit_cnt <= bit_d;
            tx_o    <= tx_d;
            busy_o  <= (state_d != IDLE);
        end
    end
endmodule

// File: tb/tb_uart_tx_7n.sv
// tb_uart_tx_7n: scoreboard bench for uart_tx_7n with a small FIFO model feeding it.
// Expected frames (bit i = i-th bit on the line) are hand-computed; UART_TX_PARITY_EN selects the parity set.
module tb_uart_tx_7n;
    localparam int P = 4, D = 7, S = 1, W = 8;
`ifdef UART_TX_PARITY_EN
    localparam int FB = 1 + D + 1 + S;
    localparam logic [9:0] F55 = 10'h2AA, F00 = 10'h200, F7F = 10'h3FE, F2A = 10'h354, F07 = 10'h30E;
`else
    localparam int FB = 1 + D + S;
    localparam logic [9:0] F55 = 10'h1AA, F00 = 10'h100, F7F = 10'h1FE, F2A = 10'h154, F07 = 10'h10E;
`endif
    localparam int FL = FB * P;

    logic clk = 1'b0;
    logic rst_i, valid_i, rd_en_o, tx_o, busy_o;
    logic [W-1:0] data_i;
    int n_cmp = 0, n_err = 0, pops = 0;
    time last_pop = 0;
    time pop_t[$];
    logic [W-1:0] fifo_q[$];
    logic [9:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_7n #(.p_clks_per_bit(P), .p_data_bits(D), .p_stop_bits(S), .p_word_size(W)) dut (
        .clk_i   (clk),
        .rst_i   (rst_i),
        .data_i  (data_i),
        .valid_i (valid_i),
        .rd_en_o (rd_en_o),
        .tx_o    (tx_o),
        .busy_o  (busy_o)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [W-1:0] w, input logic [9:0] frame);
        fifo_q.push_back(w);
        exp_q.push_back(frame);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0 || busy_o) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        chk("drain_timeout", 32'(t < 3000), 1);
    endtask

    // FIFO model: pops on edges where rd_en_o was high, presents new head after the edge
    initial begin
        logic do_pop;
        valid_i = 1'b0;
        data_i  = '0;
        forever begin
            @(negedge clk);
            do_pop = rd_en_o;
            @(posedge clk);
            if (do_pop) begin
                pops++;
                last_pop = $time;
                pop_t.push_back($time);
                if (fifo_q.size() != 0) void'(fifo_q.pop_front());
            end
            #1;
            valid_i = (fifo_q.size() != 0);
            data_i  = (fifo_q.size() != 0) ? fifo_q[0] : '0;
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            chk("pop_guard", 32'(rd_en_o & (busy_o | rst_i)), 0);
        end
    end

    // monitor: capture each frame as busy_o rises, then score it
    initial begin
        logic samp[FL];
        logic prev_busy, aborted, full, cons;
        logic [9:0] act, exp;
        prev_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (busy_o === 1'b1 && !prev_busy) begin
                chk("pop_to_start", 32'($time - last_pop), 5);
                aborted = 1'b0;
                full = 1'b1;
                for (int k = 0; k < FL; k++) begin
                    if (k > 0) @(negedge clk);
                    if (rst_i) aborted = 1'b1;
                    if (busy_o !== 1'b1) begin
                        full = 1'b0;
                        break;
                    end
                    samp[k] = tx_o;
                end
                if (!full) begin
                    if (!aborted) chk("busy_short", 0, 1);
                end else begin
                    @(negedge clk);
                    chk("busy_len", 32'(busy_o), 0);
                    act = '0;
                    cons = 1'b1;
                    for (int b = 0; b < FB; b++) begin
                        act[b] = samp[b*P];
                        for (int j = 1; j < P; j++) if (samp[b*P+j] !== samp[b*P]) cons = 1'b0;
                    end
                    chk("bit_width", 32'(cons), 1);
                    if (exp_q.size() == 0) chk("unexpected_frame", 32'(act), 0);
                    else begin
                        exp = exp_q.pop_front();
                        chk("frame_bits", 32'(act), 32'(exp));
                    end
                end
            end
            prev_busy = (busy_o === 1'b1);
        end
    end

    initial begin
        int p0;
        rst_i = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            chk("rst_tx", 32'(tx_o), 1);
            chk("rst_busy", 32'(busy_o), 0);
            chk("rst_rd_en", 32'(rd_en_o), 0);
        end
        rst_i = 1'b0;
        repeat (100) begin
            @(negedge clk);
            chk("idle_line", {29'd0, tx_o, busy_o, rd_en_o}, 32'b100);
        end
        chk("idle_pops", pops, 0);

        p0 = pops;
        push(8'h55, F55);
        wait_idle();
        chk("single_pops", pops - p0, 1);

        p0 = pops;
        push(8'h00, F00);
        push(8'h7F, F7F);
        wait_idle();
        chk("b2b_pops", pops - p0, 2);
        chk("b2b_spacing", 32'(pop_t[pop_t.size()-1] - pop_t[pop_t.size()-2]), (FL + 1) * 10);

        push(8'h2A, F2A);
        wait_idle();
        p0 = pops;
        repeat (100) begin
            @(negedge clk);
            chk("empty_line", {30'd0, tx_o, busy_o}, 32'b10);
        end
        chk("empty_pops", pops - p0, 0);

        p0 = pops;
        fifo_q.push_back(8'h55);
        for (int t = 0; t < 50 && pops == p0; t++) @(posedge clk);
        #1;
        chk("abort_pop", pops - p0, 1);
        repeat (17) @(posedge clk);
        #1;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_tx", 32'(tx_o), 1);
        chk("abort_busy", 32'(busy_o), 0);
        @(posedge clk);
        #1;
        rst_i = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_no_repop", pops - p0, 1);
        chk("abort_line", 32'(tx_o), 1);
        push(8'h2A, F2A);
        wait_idle();
        chk("abort_fresh_pop", pops - p0, 2);

        push(8'h07, F07);
        wait_idle();

        chk("exp_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
